dqn_layer_memory: RTL and testbench

Parametrised per-network parameter store for the DQN datapath: one activation (data) RAM addressed by layer/node and one weight RAM holding all three weight layers back to back. The weight port is burst oriented: a single start command streams a whole layer in or out with valid/ready handshaking. This lets the feed-forward and back-propagation engines, and the policy-to-target copy path, move a full layer without per-word addressing. One instance is used per network (policy and target).

---
 rtl/dqn_layer_memory.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_dqn_layer_memory.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dqn_layer_memory.sv
// Per-network parameter store: activation RAM addressed by layer/node plus a
// burst-oriented weight RAM. Optional illegal-request flag: LAYER_MEM_ERR_EN.
module dqn_layer_memory #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  localparam int MAX_NODE_A =
    (NUMBER_OF_INPUT_NODE > NUMBER_OF_HIDDEN_NODE_LAYER_1) ?
    NUMBER_OF_INPUT_NODE : NUMBER_OF_HIDDEN_NODE_LAYER_1,
  localparam int MAX_NODE_B =
    (NUMBER_OF_HIDDEN_NODE_LAYER_2 > NUMBER_OF_OUTPUT_NODE) ?
    NUMBER_OF_HIDDEN_NODE_LAYER_2 : NUMBER_OF_OUTPUT_NODE,
  localparam int MAX_NODE = (MAX_NODE_A > MAX_NODE_B) ? MAX_NODE_A : MAX_NODE_B,
  localparam int DATA_ADDR_WIDTH = (MAX_NODE > 1) ? $clog2(MAX_NODE) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // Activation port
  input  logic                       i_data_enable,
  input  logic                       i_rw_data_select,
  input  logic [LAYER_WIDTH-1:0]     i_data_layer,
  input  logic [DATA_ADDR_WIDTH-1:0] i_data_addr,
  input  logic [DATA_WIDTH-1:0]      i_data,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_data_valid,
  // Weight burst port
  input  logic                       i_weight_start,
  input  logic                       i_rw_weight_select,
  input  logic [LAYER_WIDTH-1:0]     i_weight_layer,
  input  logic [DATA_WIDTH-1:0]      i_weight,
  input  logic                       i_weight_valid,
  output logic                       o_weight_ready,
  output logic [DATA_WIDTH-1:0]      o_weight,
  output logic                       o_weight_valid,
  input  logic                       i_weight_ready,
  output logic                       o_weight_last,
  output logic                       o_weight_done,
  output logic                       o_busy,
  output logic                       o_error
);

  localparam int IN  = NUMBER_OF_INPUT_NODE;
  localparam int H1  = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int H2  = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int OUT = NUMBER_OF_OUTPUT_NODE;

  localparam int W1      = (IN + 1) * H1;
  localparam int W2      = (H1 + 1) * H2;
  localparam int W3      = (H2 + 1) * OUT;
  localparam int W_TOTAL = W1 + W2 + W3;
  localparam int D_TOTAL = IN + H1 + H2 + OUT;

  localparam int WADDR_W = (W_TOTAL > 1) ? $clog2(W_TOTAL) : 1;
  localparam int DADDR_W = (D_TOTAL > 1) ? $clog2(D_TOTAL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR
  } state_e;

  function automatic int node_count(input int layer);
    case (layer)
      0:       return IN;
      1:       return H1;
      2:       return H2;
      3:       return OUT;
      default: return 0;
    endcase
  endfunction

  function automatic int data_base(input int layer);
    case (layer)
      1:       return IN;
      2:       return IN + H1;
      3:       return IN + H1 + H2;
      default: return 0;
    endcase
  endfunction

  function automatic int weight_size(input int layer);
    case (layer)
      1:       return W1;
      2:       return W2;
      3:       return W3;
      default: return 0;
    endcase
  endfunction

  function automatic int weight_base(input int layer);
    case (layer)
      2:       return W1;
      3:       return W1 + W2;
      default: return 0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Activation RAM
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] data_mem [D_TOTAL];
  logic [DADDR_W-1:0]    data_idx;
  logic                  data_ok;
  logic                  data_we;
  logic                  data_re;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  data_valid_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data_ok  = 1'b0;
    data_idx = '0;
    if (int'(i_data_layer) <= 3 &&
        int'(i_data_addr) < node_count(int'(i_data_layer))) begin
      data_ok  = 1'b1;
      data_idx = DADDR_W'(data_base(int'(i_data_layer)) + int'(i_data_addr));
    end
  end

  assign data_we = i_data_enable && !i_rw_data_select && data_ok;
  assign data_re = i_data_enable &&  i_rw_data_select && data_ok;

  // NOTE: RAM arrays carry no reset; only the control and output registers around them do.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[data_idx] <= i_data;
    end
  end

  // NOTE: sequential state is always updated with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= data_re;
      if (data_re) begin
        data_q <= data_mem[data_idx];
      end
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = data_valid_q;

  // ---------------------------------------------------------------------------
  // Weight RAM and burst FSM
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] weight_mem [W_TOTAL];

  state_e                state_q;
  logic [WADDR_W-1:0]    base_q;
  logic [WADDR_W-1:0]    last_idx_q;
  logic [WADDR_W-1:0]    cnt_q;
  logic                  fetched_all_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wvalid_q;
  logic                  wlast_q;
  logic                  wready_q;
  logic                  done_q;
  logic                  busy_q;

  logic [WADDR_W-1:0]    w_addr;
  logic                  w_layer_ok;
  logic                  w_we;
  logic                  rd_accept;
  logic                  rd_fetch;
  int                    wl;

  assign wl         = int'(i_weight_layer);
  assign w_layer_ok = (wl >= 1) && (wl <= 3);
  assign w_addr     = base_q + cnt_q;

  // Writes are held off during reset so an aborted burst leaves only
  // words accepted before the reset edge.
  assign w_we      = rst_n && (state_q == ST_WR) && i_weight_valid;
  assign rd_accept = wvalid_q && i_weight_ready;
  // Output register refills whenever it is empty or being drained this cycle.
  assign rd_fetch  = (state_q == ST_RD) && !fetched_all_q &&
                     (!wvalid_q || i_weight_ready);

  always_ff @(posedge clk) begin
    if (w_we) begin
      weight_mem[w_addr] <= i_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      last_idx_q    <= '0;
      cnt_q         <= '0;
      fetched_all_q <= 1'b0;
      wdata_q       <= '0;
      wvalid_q      <= 1'b0;
      wlast_q       <= 1'b0;
      wready_q      <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (i_weight_start && w_layer_ok) begin
            base_q        <= WADDR_W'(weight_base(wl));
            last_idx_q    <= WADDR_W'(weight_size(wl) - 1);
            cnt_q         <= '0;
            fetched_all_q <= 1'b0;
            busy_q        <= 1'b1;
            if (i_rw_weight_select) begin
              state_q <= ST_RD;
            end else begin
              state_q  <= ST_WR;
              wready_q <= 1'b1;
            end
          end
        end

        ST_RD: begin
          if (rd_accept && wlast_q) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (rd_fetch) begin
            wdata_q       <= weight_mem[w_addr];
            wvalid_q      <= 1'b1;
            wlast_q       <= (cnt_q == last_idx_q);
            fetched_all_q <= (cnt_q == last_idx_q);
            cnt_q         <= cnt_q + 1'b1;
          end
        end

        ST_WR: begin
          if (i_weight_valid) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == last_idx_q) begin
              wready_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_weight       = wdata_q;
  assign o_weight_valid = wvalid_q;
  assign o_weight_last  = wlast_q;
  assign o_weight_ready = wready_q;
  assign o_weight_done  = done_q;
  assign o_busy         = busy_q;

  // ---------------------------------------------------------------------------
  // Illegal-request flag
  // ---------------------------------------------------------------------------
`ifdef LAYER_MEM_ERR_EN
  logic error_q;
  logic bad_data;
  logic bad_start;

  assign bad_data  = i_data_enable && !data_ok;
  assign bad_start = i_weight_start && ((state_q != ST_IDLE) || !w_layer_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (bad_data || bad_start) begin
      error_q <= 1'b1;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_dqn_layer_memory.sv
// Directed self-checking bench for dqn_layer_memory: data port, weight
// write/read bursts with backpressure, ignored requests, reset mid-burst.
module tb_dqn_layer_memory;

  localparam int DW  = 32;
  localparam int LW  = 2;
  localparam int AW  = 5;
  localparam int IN  = 2;
  localparam int H1  = 32;
  localparam int H2  = 32;
  localparam int OUT = 3;
  localparam int W1  = (IN + 1) * H1;
  localparam int W2  = (H1 + 1) * H2;
  localparam int W3  = (H2 + 1) * OUT;
  localparam int W_TOTAL = W1 + W2 + W3;

`ifdef LAYER_MEM_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_data_enable = 1'b0;
  logic          i_rw_data_select = 1'b0;
  logic [LW-1:0] i_data_layer = '0;
  logic [AW-1:0] i_data_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          i_weight_start = 1'b0;
  logic          i_rw_weight_select = 1'b0;
  logic [LW-1:0] i_weight_layer = '0;
  logic [DW-1:0] i_weight = '0;
  logic          i_weight_valid = 1'b0;
  logic          o_weight_ready;
  logic [DW-1:0] o_weight;
  logic          o_weight_valid;
  logic          i_weight_ready = 1'b0;
  logic          o_weight_last;
  logic          o_weight_done;
  logic          o_busy;
  logic          o_error;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] wmodel [W_TOTAL];

  always #5 clk = ~clk;

  dqn_layer_memory dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_data_enable      (i_data_enable),
    .i_rw_data_select   (i_rw_data_select),
    .i_data_layer       (i_data_layer),
    .i_data_addr        (i_data_addr),
    .i_data             (i_data),
    .o_data             (o_data),
    .o_data_valid       (o_data_valid),
    .i_weight_start     (i_weight_start),
    .i_rw_weight_select (i_rw_weight_select),
    .i_weight_layer     (i_weight_layer),
    .i_weight           (i_weight),
    .i_weight_valid     (i_weight_valid),
    .o_weight_ready     (o_weight_ready),
    .o_weight           (o_weight),
    .o_weight_valid     (o_weight_valid),
    .i_weight_ready     (i_weight_ready),
    .o_weight_last      (o_weight_last),
    .o_weight_done      (o_weight_done),
    .o_busy             (o_busy),
    .o_error            (o_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int wsize(input int layer);
    return (layer == 1) ? W1 : (layer == 2) ? W2 : W3;
  endfunction

  function automatic int wbase(input int layer);
    return (layer == 1) ? 0 : (layer == 2) ? W1 : W1 + W2;
  endfunction

  // Drives one data request in the current cycle; caller is at posedge+1.
  task automatic data_write(input int layer, input int addr, input logic [31:0] val);
    i_data_enable = 1'b1; i_rw_data_select = 1'b0;
    i_data_layer = LW'(layer); i_data_addr = AW'(addr); i_data = val;
    @(posedge clk); #1;
    i_data_enable = 1'b0;
  endtask

  task automatic data_read(input int layer, input int addr, input bit legal, input logic [31:0] exp);
    i_data_enable = 1'b1; i_rw_data_select = 1'b1;
    i_data_layer = LW'(layer); i_data_addr = AW'(addr);
    if (legal) sb.push_back(exp);
    @(posedge clk); #1;
    i_data_enable = 1'b0;
    @(negedge clk);
    check("data_valid", o_data_valid, legal);
    if (o_data_valid) check("data_value", o_data, (sb.size() > 0) ? sb.pop_front() : 'x);
    @(posedge clk); #1;
    check("data_valid_pulse", o_data_valid, 0);
  endtask

  task automatic wr_burst(input int layer, input logic [31:0] val_base, input int abort_at);
    int idx = 0;
    int ndone = 0;
    int size = wsize(layer);
    bit aborted = 1'b0;
    @(posedge clk); #1;
    i_weight_start = 1'b1; i_rw_weight_select = 1'b0; i_weight_layer = LW'(layer);
    @(posedge clk); #1;
    i_weight_start = 1'b0; i_weight_valid = 1'b1; i_weight = val_base;
    for (int c = 0; c < size + 4; c++) begin
      @(negedge clk);
      if (c == 0) check("wr_ready_first", o_weight_ready, 1);
      if (o_weight_done) begin
        ndone++;
        check("wr_busy_in_done", o_busy, 1);
      end
      if (o_weight_ready && i_weight_valid) begin
        wmodel[wbase(layer) + idx] = i_weight;
        idx++;
      end
      @(posedge clk); #1;
      if (abort_at >= 0 && idx == abort_at) begin
        aborted = 1'b1;
        break;
      end
      i_weight = val_base + idx;
    end
    if (aborted) begin
      rst_n = 1'b0;
      i_weight = val_base + idx;
      @(posedge clk); #1;
      rst_n = 1'b1;
      i_weight_valid = 1'b0;
      @(negedge clk);
      check("rst_ready", o_weight_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_done", o_weight_done, 0);
      check("rst_wvalid", o_weight_valid, 0);
      check("rst_odata", o_data, 0);
      check("rst_error", o_error, 0);
    end else begin
      i_weight_valid = 1'b0;
      check("wr_count", idx, size);
      check("wr_done_count", ndone, 1);
      @(negedge clk);
      check("wr_busy_after", o_busy, 0);
    end
  endtask

  task automatic rd_burst(input int layer, input bit toggle, input int inject_at);
    int got = 0;
    int ndone = 0;
    int first = -1;
    int size = wsize(layer);
    for (int i = 0; i < size; i++) sb.push_back(wmodel[wbase(layer) + i]);
    @(posedge clk); #1;
    i_weight_start = 1'b1; i_rw_weight_select = 1'b1; i_weight_layer = LW'(layer);
    @(posedge clk); #1;
    i_weight_start = 1'b0; i_weight_ready = 1'b1;
    for (int c = 0; c < 3 * size + 10; c++) begin
      @(negedge clk);
      if (o_weight_done) begin
        ndone++;
        check("rd_busy_in_done", o_busy, 1);
        break;
      end
      if (o_weight_valid && first < 0) first = c;
      if (o_weight_valid && i_weight_ready) begin
        check("rd_word", o_weight, (sb.size() > 0) ? sb.pop_front() : 'x);
        check("rd_last", o_weight_last, got == size - 1);
        got++;
      end
      @(posedge clk); #1;
      i_weight_ready = toggle ? ~i_weight_ready : 1'b1;
      i_weight_start = (c == inject_at);
      i_rw_weight_select = 1'b0;
      i_weight_layer = LW'(1);
    end
    i_weight_start = 1'b0;
    i_weight_ready = 1'b0;
    check("rd_count", got, size);
    check("rd_done_count", ndone, 1);
    check("rd_first_latency", first, 1);
    check("rd_sb_empty", sb.size(), 0);
    @(negedge clk);
    check("rd_busy_after", o_busy, 0);
    sb.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_odata", o_data, 0);
    check("reset_data_valid", o_data_valid, 0);
    check("reset_oweight", o_weight, 0);
    check("reset_wvalid", o_weight_valid, 0);
    check("reset_wready", o_weight_ready, 0);
    check("reset_wlast", o_weight_last, 0);
    check("reset_done", o_weight_done, 0);
    check("reset_busy", o_busy, 0);
    check("reset_error", o_error, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Data port, including the ignored out-of-range node and top boundary
    data_write(1, 0, 32'h1111_1111);
    data_write(1, 5, 32'h3F80_0000);
    data_read(1, 5, 1'b1, 32'h3F80_0000);
    data_write(0, 2, 32'hDEAD_BEEF);
    data_read(1, 0, 1'b1, 32'h1111_1111);
    data_read(0, 2, 1'b0, '0);
    data_write(3, 2, 32'hCAFE_0003);
    data_read(3, 2, 1'b1, 32'hCAFE_0003);
    check("error_after_data", o_error, ERR_EXP);

    // Layer 2 write/read with backpressure toggling every cycle
    wr_burst(2, 32'h0, -1);
    rd_burst(2, 1'b1, -1);

    // Distinct layers 1 and 3; layer-1 read with ready held high
    wr_burst(1, 32'h1000_0000, -1);
    wr_burst(3, 32'h3000_0000, -1);
    rd_burst(1, 1'b0, -1);

    // Layer 0 start ignored
    @(posedge clk); #1;
    i_weight_start = 1'b1; i_rw_weight_select = 1'b1; i_weight_layer = '0;
    @(posedge clk); #1;
    i_weight_start = 1'b0;
    @(negedge clk);
    check("layer0_busy", o_busy, 0);
    @(negedge clk);
    check("layer0_wvalid", o_weight_valid, 0);
    check("layer0_done", o_weight_done, 0);

    // Layer-3 read with a start injected mid-burst
    rd_burst(3, 1'b0, 20);
    check("error_after_ignored_start", o_error, ERR_EXP);

    // Reset at word 40 of a write burst, then a full burst and readback
    wr_burst(1, 32'h5000_0000, 40);
    wr_burst(1, 32'h7000_0000, -1);
    rd_burst(1, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
